// File: rtl/street_lane_scroller.sv
// -----------------------------------------------------------------------------
// street_lane_scroller
//
// Lane-marking generator for the scrolling street background. It keeps
// NUM_TILES dash tiles stacked in one vertical lane. Once per frame it moves
// every tile by a per-level signed speed. A tile that leaves one edge of the
// tile ring re-enters at the other edge. Draw requests and the colour are
// registered, so they lag pixelX/pixelY by one cycle.
//
// Ports
//   clk                  system clock
//   reset                synchronous, active-high reset (highest priority)
//   startOfFrame         one-cycle pulse per frame; advances the tiles when running
//   startOfLevel         one-cycle pulse; reloads tile positions and latches speed
//   levelSpeed           signed pixels per frame, positive scrolls down
//   pause                freezes motion while high
//   solidMode            1 = continuous line over the visible screen, 0 = dashed
//   pixelX, pixelY       current VGA pixel coordinates
//   drawingRequestVector per-tile hit (registered)
//   drawingRequest       combined hit, or lane hit in solid mode (registered)
//   RGBout               COLOR when drawingRequest is high, else 8'h00 (registered)
// -----------------------------------------------------------------------------
module street_lane_scroller #(
    parameter int          NUM_TILES = 11,
    parameter int          TILE_W    = 8,
    parameter int          TILE_H    = 32,
    parameter int          PITCH     = 48,
    parameter int          LANE_X    = 316,
    parameter int          SCREEN_H  = 480,
    parameter int          SPEED_W   = 8,
    parameter logic [7:0]  COLOR     = 8'hFF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic                      startOfLevel,
    input  logic signed [SPEED_W-1:0] levelSpeed,
    input  logic                      pause,
    input  logic                      solidMode,
    input  logic [10:0]               pixelX,
    input  logic [10:0]               pixelY,
    output logic [NUM_TILES-1:0]      drawingRequestVector,
    output logic                      drawingRequest,
    output logic [7:0]                RGBout
);

    // The tiles cover the band [-PITCH, SPAN-PITCH). That band is the
    // visible screen plus one pitch of slack above it.
    localparam int                 SPAN    = NUM_TILES * PITCH;
    localparam logic signed [11:0] SPAN_S  = 12'(SPAN);
    localparam logic signed [11:0] WRAP_HI = 12'(SPAN - PITCH);
    localparam logic signed [11:0] WRAP_LO = -12'(PITCH);
    localparam logic signed [11:0] PITCH_S = 12'(PITCH);
    localparam logic signed [11:0] TILE_HS = 12'(TILE_H);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic signed [SPEED_W-1:0] speed_reg;
    logic signed [SPEED_W-1:0] speed_clamped;
    logic signed [11:0]        level_speed_wide;
    logic                      move;
    logic                      x_in_lane;
    logic                      y_visible;
    logic signed [11:0]        pixel_y_s;
    logic [NUM_TILES-1:0]      hit;
    logic                      request_next;

    // ------------------------------------------------------------------
    // Motion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (startOfLevel) begin
            state_next = pause ? PAUSED : RUN;
        end else begin
            case (state_reg)
                RUN:     if (pause)  state_next = PAUSED;
                PAUSED:  if (!pause) state_next = RUN;
                default: state_next = state_reg;
            endcase
        end
    end

    // A level reload takes precedence over a frame step in the same cycle.
    assign move = (state_reg == RUN) && startOfFrame && !startOfLevel;

    // ------------------------------------------------------------------
    // Speed latch. Clamping to one pitch keeps every tile inside the
    // band after at most one wrap correction.
    // ------------------------------------------------------------------
    assign level_speed_wide = 12'(levelSpeed);

    always_comb begin
        speed_clamped = levelSpeed;
        if (level_speed_wide > PITCH_S) begin
            speed_clamped = SPEED_W'(PITCH_S);
        end else if (level_speed_wide < -PITCH_S) begin
            speed_clamped = SPEED_W'(-PITCH_S);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            speed_reg <= '0;
        end else if (startOfLevel) begin
            speed_reg <= speed_clamped;
        end
    end

    // ------------------------------------------------------------------
    // Pixel qualifiers shared by all tiles
    // ------------------------------------------------------------------
    assign x_in_lane = (pixelX >= 11'(LANE_X)) && (pixelX < 11'(LANE_X + TILE_W));
    assign y_visible = (pixelY < 11'(SCREEN_H));
    assign pixel_y_s = signed'({1'b0, pixelY});

    // ------------------------------------------------------------------
    // Per-tile position register, wrap logic and hit detector
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_tile
            logic signed [10:0] tile_y_reg;
            logic signed [11:0] top;
            logic signed [11:0] sum;
            logic signed [11:0] wrapped;

            assign top = 12'(tile_y_reg);
            assign sum = top + 12'(speed_reg);

            always_comb begin
                wrapped = sum;
                if (sum >= WRAP_HI) begin
                    wrapped = sum - SPAN_S;
                end else if (sum < WRAP_LO) begin
                    wrapped = sum + SPAN_S;
                end
            end

            always_ff @(posedge clk) begin
                if (reset || startOfLevel) begin
                    tile_y_reg <= 11'(gi * PITCH);
                end else if (move) begin
                    tile_y_reg <= 11'(wrapped);
                end
            end

            // The compare is signed, so a tile above the screen (top < 0)
            // draws only the rows that are on screen.
            assign hit[gi] = x_in_lane && (pixel_y_s >= top) && (pixel_y_s < top + TILE_HS);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registered draw outputs. The outputs are blank until a level starts.
    // ------------------------------------------------------------------
    always_comb begin
        request_next = 1'b0;
        if (state_reg != IDLE) begin
            request_next = solidMode ? (x_in_lane && y_visible) : (|hit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drawingRequestVector <= '0;
            drawingRequest       <= 1'b0;
            RGBout               <= 8'h00;
        end else begin
            drawingRequestVector <= (state_reg != IDLE) ? hit : '0;
            drawingRequest       <= request_next;
            RGBout               <= request_next ? COLOR : 8'h00;
        end
    end

endmodule

// File: tb/tb_street_lane_scroller.sv
// -----------------------------------------------------------------------------
// Testbench for street_lane_scroller. A behavioural model keeps the tile tops
// as plain integers and is advanced once per clock inside tick(). After each
// edge, tick() compares every registered output against the model. Directed
// steps pin the model to hand-computed values. A randomized phase then runs
// against the same model.
// -----------------------------------------------------------------------------
module tb_street_lane_scroller;

    localparam int N     = 11;
    localparam int PITCH = 48;
    localparam int SPAN  = N * PITCH;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              startOfFrame = 1'b0;
    logic              startOfLevel = 1'b0;
    logic signed [7:0] levelSpeed = '0;
    logic              pause = 1'b0;
    logic              solidMode = 1'b0;
    logic [10:0]       pixelX = '0;
    logic [10:0]       pixelY = '0;
    logic [N-1:0]      drawingRequestVector;
    logic              drawingRequest;
    logic [7:0]        RGBout;

    int tests  = 0;
    int errors = 0;

    // Behavioural model state
    int m_y [N];
    int m_speed   = 0;
    bit m_started = 0;   // a level has begun since reset
    bit m_frozen  = 0;   // pause level seen on the previous cycle

    logic [N-1:0] e_vec;
    logic         e_req;
    logic [7:0]   e_rgb;

    street_lane_scroller dut (
        .clk                  (clk),
        .reset                (reset),
        .startOfFrame         (startOfFrame),
        .startOfLevel         (startOfLevel),
        .levelSpeed           (levelSpeed),
        .pause                (pause),
        .solidMode            (solidMode),
        .pixelX               (pixelX),
        .pixelY               (pixelY),
        .drawingRequestVector (drawingRequestVector),
        .drawingRequest       (drawingRequest),
        .RGBout               (RGBout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // One clock cycle: predict the outputs from the current inputs and the
    // model state, advance the model, then compare after the edge.
    task automatic tick();
        bit xin;
        int y;
        int py;
        int ls;
        py  = int'(pixelY);
        xin = (pixelX >= 11'd316) && (pixelX < 11'd324);
        if (reset) begin
            e_vec = '0;
            e_req = 1'b0;
        end else begin
            for (int i = 0; i < N; i++)
                e_vec[i] = m_started && xin && (py >= m_y[i]) && (py < m_y[i] + 32);
            e_req = m_started && (solidMode ? (xin && py < 480) : (|e_vec));
        end
        e_rgb = e_req ? 8'hFF : 8'h00;

        if (reset) begin
            for (int i = 0; i < N; i++) m_y[i] = i * PITCH;
            m_speed   = 0;
            m_started = 0;
            m_frozen  = 0;
        end else if (startOfLevel) begin
            for (int i = 0; i < N; i++) m_y[i] = i * PITCH;
            ls = int'(levelSpeed);
            if (ls > PITCH) ls = PITCH;
            if (ls < -PITCH) ls = -PITCH;
            m_speed   = ls;
            m_started = 1;
            m_frozen  = pause;
        end else begin
            if (m_started && !m_frozen && startOfFrame) begin
                for (int i = 0; i < N; i++) begin
                    y = m_y[i] + m_speed;
                    if (y >= SPAN - PITCH) y -= SPAN;
                    else if (y < -PITCH) y += SPAN;
                    m_y[i] = y;
                end
            end
            m_frozen = pause;
        end

        @(posedge clk);
        #1;
        chk("vec", 32'(drawingRequestVector), 32'(e_vec));
        chk("req", 32'(drawingRequest), 32'(e_req));
        chk("rgb", 32'(RGBout), 32'(e_rgb));
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        tick();
    endtask

    task automatic level(input logic signed [7:0] spd);
        levelSpeed   = spd;
        startOfLevel = 1'b1;
        tick();
        startOfLevel = 1'b0;
    endtask

    task automatic probe(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
        tick();
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("reset_vec", 32'(drawingRequestVector), 0);
        chk("reset_rgb", 32'(RGBout), 0);
        reset = 1'b0;
        tick();

        // Level at speed 4, first tile visible at the top
        level(8'sd4);
        probe(318, 10);
        chk("lit_vec0", 32'(drawingRequestVector), 1);
        chk("lit_rgb_ff", 32'(RGBout), 32'hFF);
        probe(318, 40);
        chk("lit_gap", 32'(drawingRequest), 0);

        // 12 frames at speed 4 shift the pattern by one pitch
        repeat (12) frame();
        chk("lit_m_t0_48", m_y[0], 48);
        chk("lit_m_t10_0", m_y[10], 0);
        probe(318, 0);
        chk("lit_vec_t10", 32'(drawingRequestVector), 32'h400);

        // Negative speed wraps from above the band to the bottom
        level(-8'sd5);
        repeat (10) frame();
        chk("lit_m_t0_478", m_y[0], 478);
        probe(316, 479);
        chk("lit_vec_bottom", 32'(drawingRequestVector), 1);

        // Speed saturation at one pitch
        level(8'sd100);
        chk("lit_m_speed48", m_speed, 48);
        frame();
        chk("lit_m_t0_sat", m_y[0], 48);
        probe(318, 10);
        chk("lit_vec_sat", 32'(drawingRequestVector), 32'h400);

        // Pause freezes the tiles, and release resumes on the next frame
        level(8'sd4);
        tick();
        pause = 1'b1;
        tick();
        repeat (5) frame();
        chk("lit_m_paused", m_y[0], 0);
        pause = 1'b0;
        tick();
        frame();
        chk("lit_m_resumed", m_y[0], 4);
        probe(318, 4);
        chk("lit_vec_resume", 32'(drawingRequestVector), 1);
        probe(318, 2);
        chk("lit_vec_resume_gap", 32'(drawingRequestVector), 0);

        // A reload in the same cycle as a frame pulse wins, so there is no move
        startOfFrame = 1'b1;
        level(8'sd4);
        startOfFrame = 1'b0;
        chk("lit_m_reload", m_y[0], 0);
        probe(318, 0);
        chk("lit_vec_reload", 32'(drawingRequestVector), 1);

        // Solid mode
        solidMode = 1'b1;
        probe(320, 40);
        chk("lit_solid_req", 32'(drawingRequest), 1);
        chk("lit_solid_vec", 32'(drawingRequestVector), 0);
        chk("lit_solid_rgb", 32'(RGBout), 32'hFF);
        probe(324, 40);
        chk("lit_solid_out", 32'(drawingRequest), 0);
        solidMode = 1'b0;

        // Reset mid-frame clears the outputs on the next cycle
        probe(318, 10);
        reset = 1'b1;
        tick();
        chk("lit_rst_vec", 32'(drawingRequestVector), 0);
        chk("lit_rst_req", 32'(drawingRequest), 0);
        reset = 1'b0;
        tick();

        // Randomized phase
        level(8'sd3);
        for (int c = 0; c < 4000; c++) begin
            pixelX       = 11'(306 + $urandom_range(0, 24));
            pixelY       = 11'($urandom_range(0, 530));
            startOfFrame = ($urandom_range(0, 5) == 0);
            startOfLevel = ($urandom_range(0, 199) == 0);
            if (startOfLevel) levelSpeed = 8'($urandom);
            if ($urandom_range(0, 49) == 0) pause = ~pause;
            if ($urandom_range(0, 149) == 0) solidMode = ~solidMode;
            reset = ($urandom_range(0, 1499) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
